mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register; feeds the MEM/WB register.
//  Runs data-memory accesses over a req/ack bus with a 3-state FSM and formats write bytes/byte-enables.
//  Sign/zero-extends load data and raises a pipeline stall while an access is outstanding.
//  Non-memory instructions pass through with zero added latency.
// PARAMETERS
//  ADDR_W  32  width of dmem_addr (low ADDR_W bits of alu_result_in)
// PORTS
//  clk             in   1   system clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  RegWrite_in     in   1   from EX/MEM
//  MemRead_in      in   1   from EX/MEM; load
//  MemWrite_in     in   1   from EX/MEM; store
//  MemToReg_in     in   1   from EX/MEM
//  alu_result_in   in   32  effective address / ALU result
//  write_data_in   in   32  store data, right-aligned
//  instruction_in  in   32  funct3 = [14:12]
//  rd_in           in   5   destination register
//  RegWrite_out    out  1   to MEM/WB
//  MemToReg_out    out  1   to MEM/WB
//  alu_result_out  out  32  to MEM/WB
//  mem_data_out    out  32  formatted load data, to MEM/WB
//  rd_out          out  5   to MEM/WB
//  instruction_out out  32  to MEM/WB
//  stall_out       out  1   freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB loads only when 0
//  misalign_out    out  1   misaligned access flag (see CONFIGURATION)
//  dmem_req        out  1   bus request, registered
//  dmem_we         out  1   1=write
//  dmem_addr       out  ADDR_W  word-aligned address ([1:0]=00)
//  dmem_wdata      out  32  lane-replicated write data
//  dmem_be         out  4   byte enables
//  dmem_ack        in   1   one-cycle completion pulse; rdata valid with it
//  dmem_rdata      in   32  read word
// BEHAVIOUR
//  memop = MemRead_in|MemWrite_in. funct3 = instruction_in[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU; others = W.
//  FSM: IDLE, REQ, RESP.
//  IDLE & memop: stall_out=1. At the clock edge, latch addr/we/be/wdata/funct3, set dmem_req=1, go to REQ.
//  REQ: stall_out=1; dmem_req/addr/we/be/wdata held stable until dmem_ack.
//   On ack: capture dmem_rdata into load_buf, clear dmem_req, go to RESP.
//  RESP: stall_out=0 for exactly one cycle; MEM/WB captures at the end of that cycle. Then go to IDLE.
//  Latency with zero-wait memory (ack in first REQ cycle): stall high 2 cycles, result in the 3rd cycle.
//  IDLE & !memop: stall_out=0, no request.
//  dmem_ack seen in IDLE/RESP is ignored.
//  Upstream holds all *_in stable while stall_out=1.
//  Pass-through (combinational): RegWrite/MemToReg/alu_result/rd/instruction _out = _in.
//   Exception: RegWrite_out is forced 0 on a trapped misalign.
//  mem_data_out = formatted load_buf in RESP; 32'h0 in all other states.
//  Store lanes:
//   B -> be = 4'b0001 << addr[1:0], wdata = {4{wd[7:0]}}
//   H -> be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
//   W -> be = 1111, wdata = wd
//   Loads: dmem_be=1111, dmem_we=0.
//  Load format: select byte/half from load_buf by latched addr[1:0]; B/H sign-extend, BU/HU zero-extend.
//  Reset (any state, mid-transaction included): state=IDLE; dmem_req/we/addr/wdata/be = 0; load_buf=0.
//   dmem_req drops immediately (async). An in-flight ack after reset is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   H with addr[0]=1, or W with addr[1:0]!=0, in IDLE -> misalign_out=1 (comb).
//   No dmem_req, stall_out=0, RegWrite_out=0, FSM stays in IDLE.
//  MISALIGN_TRAP_EN undefined: misalign_out tied 0.
//   H uses addr[1] only; W ignores addr[1:0]; the access is performed.
// TESTING
//  1 rst; LW 0x100, ack 1st REQ cycle, rdata 32'hDEADBEEF -> req 1 cycle, stall 2 cycles, mem_data_out DEADBEEF in RESP.
//  2 rdata 32'h80FFFF7F:
//    LB 0x103 -> FFFFFF80; LBU 0x103 -> 00000080; LH 0x102 -> FFFF80FF; LHU 0x102 -> 000080FF; LB 0x100 -> 0000007F.
//  3 SB 0x21 wd 0xAB -> we=1, be=0010, wdata=ABABABAB, addr=0x20.
//    SH 0x22 wd 0x1234 -> be=1100, wdata=12341234.
//  4 ack delayed 3 cycles -> req/addr/be/wdata stable, stall high 4 cycles, single RESP.
//    ADD (no memop) -> stall 0, pass-through same cycle.
//  5 rst asserted in REQ -> req falls without a clock edge. Late ack ignored; next LW completes normally.
//  6 LW 0x102: with MISALIGN_TRAP_EN -> misalign_out=1, no req, RegWrite_out=0.
//    Without -> access at 0x100, misalign_out=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory sequencer, store lane formatting, load extension.
// Optional compile-time macro MISALIGN_TRAP_EN turns misaligned H/W accesses into traps.
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       write_data_in,
  input  logic [31:0]       instruction_in,
  input  logic [4:0]        rd_in,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       mem_data_out,
  output logic [4:0]        rd_out,
  output logic [31:0]       instruction_out,
  output logic              stall_out,
  output logic              misalign_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  // state | meaning
  // IDLE  | no access outstanding; memop launches one
  // REQ   | dmem_req high, bus outputs frozen until dmem_ack
  // RESP  | load data valid, stall released for one cycle
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_in, f3_q;
  logic [1:0]  lo_q;
  logic [31:0] load_buf, fmt_data, wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be_d;
  logic        memop, is_b, is_h, mis, start;
  logic        unused_instr_bits;

  assign memop = MemRead_in | MemWrite_in;
  assign f3_in = instruction_in[14:12];
  assign is_b  = (f3_in == 3'b000) || (f3_in == 3'b100);
  assign is_h  = (f3_in == 3'b001) || (f3_in == 3'b101);
  assign unused_instr_bits = ^{instruction_in[31:15], instruction_in[11:0]};

`ifdef MISALIGN_TRAP_EN
  assign mis = (state_q == IDLE) && memop &&
               ((is_h && alu_result_in[0]) || (!is_b && !is_h && (alu_result_in[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif
  assign misalign_out = mis;

  assign RegWrite_out    = RegWrite_in & ~mis;
  assign MemToReg_out    = MemToReg_in;
  assign alu_result_out  = alu_result_in;
  assign rd_out          = rd_in;
  assign instruction_out = instruction_in;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = write_data_in;
    if (MemWrite_in) begin
      if (is_b) begin
        be_d    = 4'b0001 << alu_result_in[1:0];
        wdata_d = {4{write_data_in[7:0]}};
      end else if (is_h) begin
        be_d    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{write_data_in[15:0]}};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: if (memop && !mis) begin
        stall_out = 1'b1;
        start     = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        stall_out = 1'b1;
        if (dmem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Bus outputs are latched at launch so they stay frozen for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'b0000;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      load_buf   <= 32'h0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite_in;
      dmem_addr  <= {alu_result_in[ADDR_W-1:2], 2'b00};
      dmem_wdata <= wdata_d;
      dmem_be    <= be_d;
      f3_q       <= f3_in;
      lo_q       <= alu_result_in[1:0];
    end else if (state_q == REQ && dmem_ack) begin
      dmem_req <= 1'b0;
      load_buf <= dmem_rdata;
    end
  end

  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = load_buf[7:0];
      2'd1:    byte_sel = load_buf[15:8];
      2'd2:    byte_sel = load_buf[23:16];
      default: byte_sel = load_buf[31:24];
    endcase
    half_sel = lo_q[1] ? load_buf[31:16] : load_buf[15:0];
    case (f3_q)
      3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  fmt_data = {24'h0, byte_sel};
      3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  fmt_data = {16'h0, half_sel};
      default: fmt_data = load_buf;
    endcase
  end

  assign mem_data_out = (state_q == RESP) ? fmt_data : 32'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inline bus responder, scoreboard queue of expected load data.
// Covers the MISALIGN_TRAP_EN build when that macro is defined for the bench too.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWrite_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0, MemToReg_in = 1'b0;
  logic [31:0] alu_result_in = 32'h0, write_data_in = 32'h0, instruction_in = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        RegWrite_out, MemToReg_out, stall_out, misalign_out;
  logic [31:0] alu_result_out, mem_data_out, instruction_out;
  logic [4:0]  rd_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .instruction_in(instruction_in), .rd_in(rd_in),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .alu_result_out(alu_result_out),
    .mem_data_out(mem_data_out), .rd_out(rd_out), .instruction_out(instruction_out),
    .stall_out(stall_out), .misalign_out(misalign_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemRead_in     = rd;
    MemWrite_in    = wr;
    RegWrite_in    = rw;
    MemToReg_in    = rd;
    alu_result_in  = addr;
    write_data_in  = wd;
    instruction_in = {17'h0, f3, 5'd7, 7'h03};
    rd_in          = 5'd7;
  endtask

  task automatic nop();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0; MemToReg_in = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that closes RESP.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                            input int n_ack, input logic [31:0] exp_data, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    logic done      = 1'b0;
    drive(rd, wr, rd, f3, addr, wd);
    sb.push_back(exp_data);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall_out) begin
        chk({tag, " data"}, mem_data_out, sb.pop_front());
        chk({tag, " stall_cycles"}, stall_cnt, n_ack + 1);
        chk({tag, " req_cycles"}, req_cnt, n_ack);
        chk({tag, " req_dropped"}, dmem_req, 1'b0);
        chk({tag, " pass_alu"}, alu_result_out, addr);
        chk({tag, " pass_instr"}, instruction_out, {17'h0, f3, 5'd7, 7'h03});
        done = 1'b1;
        nop();
      end else begin
        stall_cnt++;
        chk({tag, " misalign"}, misalign_out, 1'b0);
        chk({tag, " data_while_stalled"}, mem_data_out, 32'h0);
        if (dmem_req) begin
          req_cnt++;
          chk({tag, " addr"}, dmem_addr, exp_addr);
          chk({tag, " be"}, dmem_be, exp_be);
          chk({tag, " we"}, dmem_we, wr);
          if (wr) chk({tag, " wdata"}, dmem_wdata, exp_wdata);
          if (req_cnt == n_ack) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
          end
        end
      end
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
    end
    chk({tag, " completed"}, done, 1'b1);
  endtask

  initial begin
    #2;
    chk("rst req", dmem_req, 1'b0);
    chk("rst stall", stall_out, 1'b0);
    chk("rst be", dmem_be, 4'b0000);
    chk("rst mem_data", mem_data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0);

    run_access("lb103",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 1, 32'hFFFFFF80, 32'h100, 4'hF, 32'h0);
    run_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 1, 32'h00000080, 32'h100, 4'hF, 32'h0);
    run_access("lh102",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80FFFF7F, 1, 32'hFFFF80FF, 32'h100, 4'hF, 32'h0);
    run_access("lhu102", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FFFF7F, 1, 32'h000080FF, 32'h100, 4'hF, 32'h0);
    run_access("lb100",  1, 0, 3'b000, 32'h100, 32'h0, 32'h80FFFF7F, 1, 32'h0000007F, 32'h100, 4'hF, 32'h0);

    run_access("sb21", 0, 1, 3'b000, 32'h21, 32'hAB,   32'h0, 1, 32'h0, 32'h20, 4'b0010, 32'hABABABAB);
    run_access("sh22", 0, 1, 3'b001, 32'h22, 32'h1234, 32'h0, 1, 32'h0, 32'h20, 4'b1100, 32'h12341234);
    run_access("sw24", 0, 1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0, 1, 32'h0, 32'h24, 4'b1111, 32'hCAFEF00D);

    run_access("lw_wait", 1, 0, 3'b010, 32'h300, 32'h0, 32'h01234567, 3, 32'h01234567, 32'h300, 4'hF, 32'h0);

    drive(0, 0, 1, 3'b000, 32'h0000_1234, 32'h0);
    rd_in = 5'd3;
    #1;
    chk("add stall", stall_out, 1'b0);
    chk("add alu", alu_result_out, 32'h1234);
    chk("add rd", rd_out, 5'd3);
    chk("add regwrite", RegWrite_out, 1'b1);
    @(negedge clk);
    chk("add no_req", dmem_req, 1'b0);
    chk("add mem_data", mem_data_out, 32'h0);
    @(posedge clk); #1;
    nop();

    drive(1, 0, 1, 3'b010, 32'h200, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid req_before", dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    nop();
    #1;
    chk("rst_mid req_async", dmem_req, 1'b0);
    chk("rst_mid stall", stall_out, 1'b0);
    chk("rst_mid addr", dmem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack req", dmem_req, 1'b0);
    chk("late_ack stall", stall_out, 1'b0);
    chk("late_ack data", mem_data_out, 32'h0);
    @(posedge clk); #1;
    run_access("lw_after_rst", 1, 0, 3'b010, 32'h104, 32'h0, 32'h13572468, 1, 32'h13572468, 32'h104, 4'hF, 32'h0);

`ifdef MISALIGN_TRAP_EN
    drive(1, 0, 1, 3'b010, 32'h102, 32'h0);
    #1;
    chk("trap misalign", misalign_out, 1'b1);
    chk("trap stall", stall_out, 1'b0);
    chk("trap regwrite", RegWrite_out, 1'b0);
    @(posedge clk); #1;
    chk("trap no_req", dmem_req, 1'b0);
    nop();
    #1;
    chk("trap cleared", misalign_out, 1'b0);
`else
    run_access("lw102", 1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 32'h100, 4'hF, 32'h0);
`endif

    chk("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
